sram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of one OpenRAM single-port RW macro (16-bit words, 256 words, active-low csb0/web0). It round-robins read/write requests from two clients onto port 0 and drives the macro's inputs from registers. It captures read data from dout0 two cycles after acceptance and returns a tagged response to the issuing client. Fully pipelined: one access per cycle, no bubbles.

---
 rtl/sram_port_arbiter_if.sv | 44 ++++
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: client request/response and SRAM port-0 bundle.
// master = clients + SRAM macro side, slave = arbiter side.
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic                  rsp_we;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_we, rsp_rdata,
        input  csb0, web0, addr0, din0,
        output dout0
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_we, rsp_rdata,
        output csb0, web0, addr0, din0,
        input  dout0
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-client round-robin arbiter for one OpenRAM RW port.
// Ports: clk0, rst0_n (async active-low), bus (sram_port_arbiter_if.slave).
// Build option SRAM_ARB_FIXED_PRIO_EN: client 0 gets strict priority.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clk0,
    input  logic                 rst0_n,
    sram_port_arbiter_if.slave   bus
);
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  sel_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  s1_valid;
    logic                  s1_id;
    logic                  s1_we;
    logic                  s2_valid;
    logic                  s2_id;
    logic                  s2_we;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                  rr_ptr;
`endif

    // Grant is held off during reset so ready never fires while in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst0_n) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
`endif
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign accept         = grant0 || grant1;
    assign sel_id         = grant1;
    assign sel_we    = grant1 ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~sel_id;
        end
    end
`endif

    // SRAM inputs: registered, deselected on any cycle without an accept.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            bus.csb0  <= 1'b1;
            bus.web0  <= 1'b1;
            bus.addr0 <= '0;
            bus.din0  <= '0;
        end else begin
            bus.csb0 <= ~accept;
            bus.web0 <= accept ? ~sel_we : 1'b1;
            if (accept) begin
                bus.addr0 <= sel_addr;
                bus.din0  <= sel_wdata;
            end
        end
    end

    // Two-stage tag pipe matching the macro's one-cycle read latency.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_we    <= 1'b0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_we    <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_id    <= sel_id;
            s1_we    <= sel_we;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_we    <= s1_we;
        end
    end

    // dout0 is only looked at for a valid read, so X never leaks out.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= s2_valid;
            if (s2_valid) begin
                bus.rsp_id    <= s2_id;
                bus.rsp_we    <= s2_we;
                bus.rsp_rdata <= s2_we ? '0 : bus.dout0;
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench with a behavioural OpenRAM port model.
// Covers reset, write/read, alternation, idle gaps and mid-flight reset.
module tb_sram_port_arbiter;
    logic clk0;
    logic rst0_n;
    int   checks;
    int   errors;

    logic [15:0] mem [256];
    logic        m_csb;
    logic        m_web;
    logic [7:0]  m_addr;
    logic [15:0] m_din;

    sram_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    sram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk0   (clk0),
        .rst0_n (rst0_n),
        .bus    (bus.slave)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Macro model: latch inputs at posedge, act on the following negedge.
    always @(posedge clk0) begin
        m_csb  <= bus.csb0;
        m_web  <= bus.web0;
        m_addr <= bus.addr0;
        m_din  <= bus.din0;
    end

    always @(negedge clk0) begin
        if (m_csb === 1'b0) begin
            if (m_web === 1'b0) mem[m_addr] = m_din;
            else bus.dout0 <= mem[m_addr];
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic set_idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst0_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b0;
        bus.req0_addr  = 8'h05;
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 8'h06;
        #12;
        checks++;
        if (bus.csb0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_csb0 got=%h exp=1", bus.csb0);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp_valid got=%h exp=0", bus.rsp_valid);
        end
        checks++;
        if (bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready0 got=%h exp=0", bus.req0_ready);
        end
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready1 got=%h exp=0", bus.req1_ready);
        end
        checks++;
        if (bus.addr0 !== 8'h00 || bus.rsp_rdata !== 16'h0) begin
            errors++;
            $display("FAIL rst_regs got=%h/%h exp=0/0",
                     bus.addr0, bus.rsp_rdata);
        end
        @(negedge clk0);
        rst0_n = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_grant got=%b%b exp=10",
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        checks++;
        if (bus.csb0 !== 1'b0 || bus.addr0 !== 8'h05) begin
            errors++;
            $display("FAIL rst_accept got=%h/%h exp=0/05",
                     bus.csb0, bus.addr0);
        end
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_rr_flip got=%b%b exp=01",
                     bus.req0_ready, bus.req1_ready);
        end
        set_idle();
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 ||
            bus.rsp_rdata !== 16'h0505) begin
            errors++;
            $display("FAIL rst_rsp got=%h/%h/%h exp=1/0/0505",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b1;
        bus.req0_addr  = 8'h10;
        bus.req0_wdata = 16'hA5A5;
        tick();
        checks++;
        if (bus.csb0 !== 1'b0 || bus.web0 !== 1'b0 ||
            bus.din0 !== 16'hA5A5) begin
            errors++;
            $display("FAIL wr_issue got=%h/%h/%h exp=0/0/a5a5",
                     bus.csb0, bus.web0, bus.din0);
        end
        bus.req0_we = 1'b0;
        tick();
        checks++;
        if (bus.csb0 !== 1'b0 || bus.web0 !== 1'b1) begin
            errors++;
            $display("FAIL rd_issue got=%h/%h exp=0/1",
                     bus.csb0, bus.web0);
        end
        set_idle();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 ||
            bus.rsp_we !== 1'b1 || bus.rsp_rdata !== 16'h0) begin
            errors++;
            $display("FAIL wr_ack got=%h/%h/%h/%h exp=1/0/1/0000",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_we,
                     bus.rsp_rdata);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_we !== 1'b0 ||
            bus.rsp_rdata !== 16'hA5A5) begin
            errors++;
            $display("FAIL raw_read got=%h/%h/%h exp=1/0/a5a5",
                     bus.rsp_valid, bus.rsp_we, bus.rsp_rdata);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.csb0 !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_drain got=%h/%h exp=0/1",
                     bus.rsp_valid, bus.csb0);
        end
    endtask

    // Previous traffic was client 0 only, so client 1 is favoured first.
    task automatic test_alternate();
        logic g;
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b0;
        bus.req0_addr  = 8'h01;
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 8'h02;
        for (int i = 0; i < 8; i++) begin
            g = (i % 2 == 0);
            #1;
            checks++;
            if (bus.req1_ready !== g || bus.req0_ready !== !g) begin
                errors++;
                $display("FAIL alt_grant[%0d] got=%b%b exp=%b%b", i,
                         bus.req0_ready, bus.req1_ready, !g, g);
            end
            tick();
            checks++;
            if (bus.addr0 !== (g ? 8'h02 : 8'h01)) begin
                errors++;
                $display("FAIL alt_addr[%0d] got=%h", i, bus.addr0);
            end
            if (i >= 2) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== g ||
                    bus.rsp_rdata !== (g ? 16'h2222 : 16'h1111)) begin
                    errors++;
                    $display("FAIL alt_rsp[%0d] got=%h/%h/%h exp=1/%h/%h",
                             i, bus.rsp_valid, bus.rsp_id,
                             bus.rsp_rdata, g,
                             g ? 16'h2222 : 16'h1111);
                end
            end
        end
        set_idle();
        for (int j = 0; j < 2; j++) begin
            g = (j == 0);
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== g ||
                bus.rsp_rdata !== (g ? 16'h2222 : 16'h1111)) begin
                errors++;
                $display("FAIL alt_tail[%0d] got=%h/%h/%h", j,
                         bus.rsp_valid, bus.rsp_id, bus.rsp_rdata);
            end
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_end got=%h exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_idle_gap();
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 8'h02;
        tick();
        set_idle();
        tick();
        checks++;
        if (bus.csb0 !== 1'b1 || bus.web0 !== 1'b1) begin
            errors++;
            $display("FAIL gap_csb got=%h/%h exp=1/1",
                     bus.csb0, bus.web0);
        end
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h01;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 ||
            bus.rsp_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL gap_rsp1 got=%h/%h/%h exp=1/1/2222",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_rdata);
        end
        set_idle();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL gap_hold got=%h/%h exp=0/2222",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL gap_rsp2 got=%h/%h exp=1/1111",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b0;
        bus.req0_addr  = 8'h01;
        tick();
        set_idle();
        #2;
        rst0_n = 1'b0;
        #1;
        checks++;
        if (bus.csb0 !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got=%h/%h exp=1/0",
                     bus.csb0, bus.rsp_valid);
        end
        tick();
        @(negedge clk0);
        rst0_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_rsp[%0d] got=%h exp=0", k,
                         bus.rsp_valid);
            end
        end
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h01;
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 8'h02;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_grant got=%b%b exp=10",
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        set_idle();
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 ||
            bus.rsp_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL mid_resume got=%h/%h/%h exp=1/0/1111",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_rdata);
        end
        tick();
    endtask

`ifdef SRAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        bus.req0_valid = 1'b1;
        bus.req0_we    = 1'b0;
        bus.req0_addr  = 8'h01;
        bus.req1_valid = 1'b1;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 8'h02;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL fix_starve[%0d] got=%b%b exp=10", i,
                         bus.req0_ready, bus.req1_ready);
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL fix_release got=%b exp=1", bus.req1_ready);
        end
        set_idle();
        tick();
        tick();
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        mem[8'h05] = 16'h0505;
        bus.req0_valid = 1'b0;
        bus.req0_we    = 1'b0;
        bus.req0_addr  = 8'h0;
        bus.req0_wdata = 16'h0;
        bus.req1_valid = 1'b0;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = 8'h0;
        bus.req1_wdata = 16'h0;
        test_reset();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_write_read();
        test_alternate();
        test_idle_gap();
        test_reset_midflight();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
